sha_round_ctrl: RTL

Sequencer that owns the 32-round SHA-256 round engine in the bitcoin miner and drives it through one full 64-round compression. It accepts a job holding the 256-bit chaining state, issues two engine segments (rounds 0-31, then 32-63), and adds the chaining state back in. It then presents the 256-bit digest on a valid/ready output. It sits between the miner top-level job FSM and the round engine; a watchdog flags a stalled engine.

---
 rtl/sha_round_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/sha_round_ctrl.sv
// Round-engine sequencer for one SHA-256 compression: two 32-round engine segments,
// chaining-state add-back, and a valid/ready digest output with a per-segment watchdog.
module sha_round_ctrl #(
   parameter int unsigned TIMEOUT = 48
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [255:0] job_state,
   output logic         rnd_en,
   output logic         rnd_seg,
   output logic [255:0] rnd_state,
   input  logic         rnd_done,
   input  logic [255:0] rnd_result,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [255:0] res_digest,
   output logic         busy,
   output logic         err
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] WdogLast = CntW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle, StS0Go, StS0Wait, StS1Go, StS1Wait, StAdd, StOut, StErr
   } state_e;

   state_e          state_q, state_d;
   logic [255:0]    chain_q, chain_d;
   logic [255:0]    work_q, work_d;
   logic [255:0]    digest_q, digest_d;
   logic [CntW-1:0] wdog_q, wdog_d;
   logic [255:0]    sum;

   // Word-wise add-back; carries must not cross 32-bit word boundaries.
   always_comb begin
      sum = '0;
      for (int i = 0; i < 8; i++) begin
         sum[i*32 +: 32] = chain_q[i*32 +: 32] + work_q[i*32 +: 32];
      end
   end

   always_comb begin
      state_d  = state_q;
      chain_d  = chain_q;
      work_d   = work_q;
      digest_d = digest_q;
      wdog_d   = wdog_q;
      unique case (state_q)
         StIdle: begin
            if (job_valid) begin
               chain_d = job_state;
               work_d  = job_state;
               state_d = StS0Go;
            end
         end
         StS0Go: begin
            wdog_d  = '0;
            state_d = StS0Wait;
         end
         StS1Go: begin
            wdog_d  = '0;
            state_d = StS1Wait;
         end
         StS0Wait, StS1Wait: begin
            // A done arriving on the last watchdog cycle still counts as success.
            if (rnd_done) begin
               work_d  = rnd_result;
               state_d = (state_q == StS0Wait) ? StS1Go : StAdd;
            end else if (wdog_q == WdogLast) begin
               state_d = StErr;
            end else begin
               wdog_d = wdog_q + CntW'(1);
            end
         end
         StAdd: begin
            digest_d = sum;
            state_d  = StOut;
         end
         StOut: begin
            if (res_ready) state_d = StIdle;
         end
         StErr: begin
            state_d = StErr;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         chain_q  <= '0;
         work_q   <= '0;
         digest_q <= '0;
         wdog_q   <= '0;
      end else begin
         state_q  <= state_d;
         chain_q  <= chain_d;
         work_q   <= work_d;
         digest_q <= digest_d;
         wdog_q   <= wdog_d;
      end
   end

   always_comb begin
      job_ready  = (state_q == StIdle);
      rnd_en     = (state_q == StS0Go) || (state_q == StS1Go);
      rnd_seg    = (state_q == StS1Go) || (state_q == StS1Wait);
      rnd_state  = work_q;
      res_valid  = (state_q == StOut);
      res_digest = digest_q;
      busy       = (state_q != StIdle) && (state_q != StErr);
      err        = (state_q == StErr);
   end

endmodule
